fpu_add_pipe: RTL and testbench
===============================

Name: fpu_add_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. Successor to the team's single-precision combinational adder.
- Adds: configurable exponent/mantissa widths, an add/sub mode bit, round-to-nearest-even with guard/round/sticky bits, special-value handling, exception flags, and a valid/ready stream interface with full backpressure.
- Sits between operand-issue logic and the result writeback buffer.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored fraction width in bits; the hidden 1 is implicit.
- W, EXP_W+MAN_W+1, derived total word width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts the pair this cycle.
- op_a  in  W  operand A as {sign, exp, frac}.
- op_b  in  W  operand B.
- op_sub  in  1  0: A+B; 1: A-B (B sign inverted at stage 1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- result  out  W  rounded sum.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result.

Behaviour:
- Reset: out_valid=0, result=0, flags=0, all stage valid bits=0. in_ready follows its combinational definition (1 after reset). Reset mid-operation discards all in-flight ops.
- Handshake: transfer occurs when valid&&ready on either side. in_ready = out_ready || !out_valid. Global stall: when out_valid&&!out_ready, all stages hold. result/flags stay stable while stalled.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 op/cycle.
- S1 (unpack/align):
  - Classify each operand as zero (exp==0, any frac; denormals flush to zero), inf, NaN, or normal.
  - Swap so the larger magnitude is operand L. Compare {exp, frac}.
  - Shift the smaller significand right by exponent difference into a MAN_W+4 field (hidden, frac, G, R, S). Shifted-out bits OR into S. Shift amounts ≥ MAN_W+3 yield S only.
- S2 (add/sub):
  - Effective subtract = sign_L^sign_S. Compute an MAN_W+5-bit sum/difference. The difference is never negative because of the swap.
  - Result sign = sign_L.
  - Exact zero difference gives +0. Exception: (-0)+(-0) gives -0.
- S3 (normalise/round):
  - Carry out: shift right 1 (preserve S), exp+1.
  - Otherwise leading-zero count, then shift left and subtract it from exp.
  - Round-to-nearest-even: increment when G && (R||S||lsb). A rounding carry renormalises and increments exp.
  - inexact = G||R||S before rounding.
- Overflow: exp ≥ all-ones. Output ±inf; set overflow and inexact.
- Underflow: normalised exp ≤ 0. Output signed zero (flush); set underflow and inexact.
- Specials (bypass arithmetic, carried through pipe):
  - Any NaN input → canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - inf + (-inf) effective → canonical qNaN, invalid=1.
  - inf ± finite → that inf, no flags.
  - Zero operand → other operand returned exactly, no flags.
- Simultaneous in/out transfer in the same cycle is legal; no bubble is inserted.

Decomposition:
- Shared package fpu_pkg:
  - Class enum {ZERO, NORM, INF, NAN}.
  - Flag bit index constants.
  - Function returning canonical qNaN for EXP_W/MAN_W.
  - Per-stage struct typedefs.
- One sub-module fpu_lzc (parametrised leading-zero counter, width MAN_W+5), instantiated in S3.

Test Plan (EXP_W=8, MAN_W=23):
- 0x3F800000 + 0x3F800000, op_sub=0, out_ready=1 → result 0x40000000, flags 0, out_valid exactly 3 cycles after acceptance.
- 0x3F800000 - 0x3F800000 (op_sub=1) → 0x00000000, flags 0. Also 0x80000000 + 0x80000000 → 0x80000000.
- 0x3F800000 + 0x33800000 → 0x3F800000, inexact (tie to even). Then 0x3F800001 + 0x33800000 → 0x3F800002, inexact.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow+inexact. Then 0x7F800000 - 0x7F800000 (op_sub=1) → 0x7FC00000, invalid.
- Backpressure: hold out_ready=0, stream 5 ops back-to-back → in_ready drops once out_valid=1. Result stays stable. Raise out_ready → all 5 results emerge in order, none lost or duplicated.
- Assert rst for 1 cycle with 3 ops in flight → next cycle out_valid=0, result=0. The following op returns correctly after 3 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
// Holds operand classes, flag bit positions, stage control and the canonical qNaN.
package fpu_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  typedef struct packed {
    logic              valid;
    logic              special;
    logic [FLAG_W-1:0] spec_flags;
  } stage_ctl_t;

  // Quiet NaN: sign 0, exponent all ones, top fraction bit set, rest clear.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 64; i++) begin
      v[i] = ((i >= man_w) && (i < man_w + exp_w)) || (i == man_w - 1);
    end
    return v;
  endfunction

  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero);
    fp_class_e c;
    if (exp_zero) begin
      c = ZERO;
    end else if (!exp_ones) begin
      c = NORM;
    end else if (frac_zero) begin
      c = INF;
    end else begin
      c = NAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  // Highest set bit wins because the scan runs upward.
  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      o_cnt = i_vec[i] ? CNT_W'(WIDTH - 1 - i) : o_cnt;
    end
  end

endmodule

// File: rtl/fpu_add_pipe.sv
// Three-stage floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero denormals and a fully back-pressured valid/ready stream.
module fpu_add_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [FLAG_W-1:0]      flags
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int SIG_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int EW2   = EXP_W + 2;
  localparam int LZW   = $clog2(SUM_W + 1);
  localparam logic [W-1:0]     QNAN     = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [W-1:0]     spec_word;
    logic             sign_l;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_l;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
  } s1_t;

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [W-1:0]     spec_word;
    logic             sign;
    logic [EXP_W-1:0] exp_l;
    logic [SUM_W-1:0] sum;
  } s2_t;

  logic             w_adv;
  logic             w_sa;
  logic             w_sb;
  logic             w_a_ge;
  fp_class_e        w_cls_a;
  fp_class_e        w_cls_b;
  logic [EXP_W-1:0] w_exp_s;
  logic [MAN_W-1:0] w_frac_l;
  logic [MAN_W-1:0] w_frac_s;
  logic [EXP_W-1:0] w_diff;
  logic [2*SIG_W-1:0] w_ext;
  s1_t              w_s1;
  s1_t              r_s1;
  s2_t              w_s2;
  s2_t              r_s2;
  logic [LZW-1:0]   w_lz;
  logic [MAN_W+2:0] w_norm;
  logic [EW2-1:0]   w_exp_n;
  logic [EW2-1:0]   w_exp_f;
  logic             w_round_up;
  logic             w_inexact;
  logic [MAN_W+1:0] w_rs;
  logic [W-1:0]     w_res;
  logic [FLAG_W-1:0] w_flags;
  logic             r_out_valid;
  logic [W-1:0]     r_result;
  logic [FLAG_W-1:0] r_flags;

  assign in_ready  = out_ready || !r_out_valid;
  assign w_adv     = in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  assign w_sa    = op_a[W-1];
  assign w_sb    = op_b[W-1] ^ op_sub;
  assign w_a_ge  = op_a[W-2:0] >= op_b[W-2:0];
  assign w_cls_a = classify(op_a[W-2:MAN_W] == {EXP_W{1'b0}}, op_a[W-2:MAN_W] == EXP_ONES,
                            op_a[MAN_W-1:0] == {MAN_W{1'b0}});
  assign w_cls_b = classify(op_b[W-2:MAN_W] == {EXP_W{1'b0}}, op_b[W-2:MAN_W] == EXP_ONES,
                            op_b[MAN_W-1:0] == {MAN_W{1'b0}});

  // S1: swap to larger magnitude, align smaller significand, resolve specials.
  always_comb begin
    w_s1             = '0;
    w_s1.ctl.valid   = in_valid;
    w_s1.eff_sub     = w_sa ^ w_sb;
    if (w_a_ge) begin
      w_s1.sign_l = w_sa;
      w_s1.exp_l  = op_a[W-2:MAN_W];
      w_frac_l    = op_a[MAN_W-1:0];
      w_exp_s     = op_b[W-2:MAN_W];
      w_frac_s    = op_b[MAN_W-1:0];
    end else begin
      w_s1.sign_l = w_sb;
      w_s1.exp_l  = op_b[W-2:MAN_W];
      w_frac_l    = op_b[MAN_W-1:0];
      w_exp_s     = op_a[W-2:MAN_W];
      w_frac_s    = op_a[MAN_W-1:0];
    end
    w_diff     = w_s1.exp_l - w_exp_s;
    w_s1.sig_l = {1'b1, w_frac_l, 3'b000};
    w_ext      = {1'b1, w_frac_s, 3'b000, {SIG_W{1'b0}}} >> w_diff;
    if (int'(w_diff) >= MAN_W + 3) begin
      w_s1.sig_s = {{(SIG_W-1){1'b0}}, 1'b1};
    end else begin
      w_s1.sig_s = w_ext[2*SIG_W-1:SIG_W] | {{(SIG_W-1){1'b0}}, |w_ext[SIG_W-1:0]};
    end

    w_s1.ctl.special = 1'b1;
    if (w_cls_a == NAN || w_cls_b == NAN) begin
      w_s1.spec_word                    = QNAN;
      w_s1.ctl.spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_cls_a == INF && w_cls_b == INF) begin
      if (w_s1.eff_sub) begin
        w_s1.spec_word                    = QNAN;
        w_s1.ctl.spec_flags[FLAG_INVALID] = 1'b1;
      end else begin
        w_s1.spec_word = op_a;
      end
    end else if (w_cls_a == INF) begin
      w_s1.spec_word = op_a;
    end else if (w_cls_b == INF) begin
      w_s1.spec_word = {w_sb, op_b[W-2:0]};
    end else if (w_cls_a == ZERO && w_cls_b == ZERO) begin
      w_s1.spec_word = {w_sa & w_sb, {(W-1){1'b0}}};
    end else if (w_cls_a == ZERO) begin
      w_s1.spec_word = {w_sb, op_b[W-2:0]};
    end else if (w_cls_b == ZERO) begin
      w_s1.spec_word = op_a;
    end else begin
      w_s1.ctl.special = 1'b0;
    end
  end

  // S2: magnitude add or subtract; swap guarantees a non-negative difference.
  always_comb begin
    w_s2           = '0;
    w_s2.ctl       = r_s1.ctl;
    w_s2.spec_word = r_s1.spec_word;
    w_s2.exp_l     = r_s1.exp_l;
    if (r_s1.eff_sub) begin
      w_s2.sum = {1'b0, r_s1.sig_l} - {1'b0, r_s1.sig_s};
    end else begin
      w_s2.sum = {1'b0, r_s1.sig_l} + {1'b0, r_s1.sig_s};
    end
    w_s2.sign = (w_s2.sum == {SUM_W{1'b0}}) ? 1'b0 : r_s1.sign_l;
  end

  fpu_lzc #(.WIDTH(SUM_W)) u_lzc (
    .i_vec (r_s2.sum),
    .o_cnt (w_lz)
  );

  // S3: normalise, round to nearest even, then apply range checks.
  always_comb begin
    if (r_s2.sum[SUM_W-1]) begin
      w_norm  = {r_s2.sum[MAN_W+3:2], r_s2.sum[1] | r_s2.sum[0]};
      w_exp_n = {2'b00, r_s2.exp_l} + EW2'(1'b1);
    end else begin
      w_norm  = (MAN_W+3)'(r_s2.sum << (w_lz - LZW'(1'b1)));
      w_exp_n = {2'b00, r_s2.exp_l} - EW2'(w_lz) + EW2'(1'b1);
    end
    w_inexact  = |w_norm[2:0];
    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rs       = {1'b0, 1'b1, w_norm[MAN_W+2:3]} + (MAN_W+2)'(w_round_up);
    w_exp_f    = w_exp_n + EW2'(w_rs[MAN_W+1]);

    w_flags = '0;
    if (r_s2.ctl.special) begin
      w_res   = r_s2.spec_word;
      w_flags = r_s2.ctl.spec_flags;
    end else if (r_s2.sum == {SUM_W{1'b0}}) begin
      w_res = {W{1'b0}};
    end else if (w_exp_n[EW2-1] || w_exp_n == {EW2{1'b0}}) begin
      w_res                   = {r_s2.sign, {(W-1){1'b0}}};
      w_flags[FLAG_UNDERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]   = 1'b1;
    end else if (w_exp_f >= {2'b00, EXP_ONES}) begin
      w_res                  = {r_s2.sign, EXP_ONES, {MAN_W{1'b0}}};
      w_flags[FLAG_OVERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      w_res = {r_s2.sign, w_exp_f[EXP_W-1:0],
               w_rs[MAN_W+1] ? w_rs[MAN_W:1] : w_rs[MAN_W-1:0]};
      w_flags[FLAG_INEXACT] = w_inexact;
    end
  end

  // Pipeline registers; every stage freezes together while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_out_valid <= r_s2.ctl.valid;
      r_result    <= w_res;
      r_flags     <= w_flags;
    end
  end

endmodule

// File: tb/tb_fpu_add_pipe.sv
// Scoreboard bench for fpu_add_pipe in single precision.
module tb_fpu_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fpu_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic        lat;
    int          cyc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] cur_r;
  logic [3:0]  cur_f;
  logic        cur_lat;
  logic        held_v;
  logic [35:0] held;
  logic        done;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.r = r; v.f = f;
    return v;
  endfunction

  // Drive one operand pair, hold until accepted; returns one step after a rising edge.
  task automatic send(input vec_t v, input logic lat);
    logic acc;
    acc      = 1'b0;
    op_a     = v.a;
    op_b     = v.b;
    op_sub   = v.sub;
    cur_r    = v.r;
    cur_f    = v.f;
    cur_lat  = lat;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check_val("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: push on input transfer, pop and compare on output transfer, watch stalls.
  initial begin
    exp_t e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check_val("spurious_out", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            check_val("result", 64'(result), 64'(e.r));
            check_val("flags", 64'(flags), 64'(e.f));
            if (e.lat) check_val("latency", 64'(cyc - e.cyc), 64'd3);
          end
        end
        if (out_valid && !out_ready) begin
          if (held_v) check_val("stall_stable", 64'({flags, result}), 64'(held));
          held   = {flags, result};
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
        if (in_valid && in_ready) begin
          e.r = cur_r; e.f = cur_f; e.lat = cur_lat; e.cyc = cyc;
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0; op_sub = 1'b0;
    out_ready = 1'b1; cur_r = 32'd0; cur_f = 4'd0; cur_lat = 1'b0; done = 1'b0;

    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000));
    vecs.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001));
    vecs.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000));
    vecs.push_back(mk(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000));
    vecs.push_back(mk(32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 4'b0000));
    vecs.push_back(mk(32'h40490FDB, 32'h00000001, 1'b0, 32'h40490FDB, 4'b0000));
    vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000));
    vecs.push_back(mk(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011));
    vecs.push_back(mk(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk(32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 4'b0000));
    vecs.push_back(mk(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_result", 64'(result), 64'd0);
    check_val("reset_flags", 64'(flags), 64'd0);
    check_val("reset_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream with no backpressure; latency checked on every op.
    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    // Full backpressure: pipe fills, input stalls, results then drain in order.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(vecs[i], 1'b0);
      end
      begin
        repeat (10) @(negedge clk);
        check_val("bp_in_ready", 64'(in_ready), 64'd0);
        check_val("bp_out_valid", 64'(out_valid), 64'd1);
        check_val("bp_in_flight", 64'(sb_q.size()), 64'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random consumer stalls across the whole table.
    done = 1'b0;
    fork
      begin
        foreach (vecs[i]) send(vecs[i], 1'b0);
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !done; k++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three ops in flight discards them all.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i], 1'b0);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("midrst_out_valid", 64'(out_valid), 64'd0);
    check_val("midrst_result", 64'(result), 64'd0);
    check_val("midrst_flags", 64'(flags), 64'd0);
    out_ready = 1'b1;
    send(vecs[5], 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
